// File: rtl/dwt_coef_packer_if.sv
// dwt_coef_packer_if: pair input strobe/data, word stream valid/ready/data/band, sticky overflow and saturation flags
interface dwt_coef_packer_if #(
    parameter int pWIDTH  = 12,
    parameter int pOWIDTH = 12
);
    logic                  iena;
    logic [2*pWIDTH-1:0]   idatH;
    logic [2*pWIDTH-1:0]   idatL;
    logic                  ordy;
    logic                  oval;
    logic [pOWIDTH-1:0]    odat;
    logic                  osel;
    logic                  oovf;
    logic                  osat;
    modport master (output iena, idatH, idatL, ordy, input oval, odat, osel, oovf, osat);
    modport slave  (input iena, idatH, idatL, ordy, output oval, odat, osel, oovf, osat);
endinterface

// File: rtl/dwt_coef_packer.sv
// dwt_coef_packer: round/shift/saturate coefficient pairs, buffer them in a pair FIFO and emit L then H words over valid/ready (iclk, irst active-low sync, bus slave)
module dwt_coef_packer #(
    parameter int pWIDTH  = 12,
    parameter int pOWIDTH = 12,
    parameter int pSHIFT  = 11,
    parameter int pDEPTH  = 8
) (
    input  logic                 iclk,
    input  logic                 irst,
    dwt_coef_packer_if.slave     bus
);
    localparam int IW = 2*pWIDTH;
    localparam int AW = $clog2(pDEPTH);
    localparam logic signed [IW:0] HI = {{(IW-pOWIDTH+2){1'b0}}, {(pOWIDTH-1){1'b1}}};
    localparam logic signed [IW:0] LO = ~HI;
    typedef enum logic {PH_L, PH_H} ph_t;
    function automatic logic [pOWIDTH:0] rq(input logic [IW-1:0] x);
        logic signed [IW:0] s;
        s = ($signed({x[IW-1], x}) + $signed((IW+1)'(1) << (pSHIFT-1))) >>> pSHIFT;
        return s > HI ? {1'b1, HI[pOWIDTH-1:0]} : s < LO ? {1'b1, LO[pOWIDTH-1:0]} : {1'b0, s[pOWIDTH-1:0]};
    endfunction
    ph_t ph, ph_n;
    logic s_val, ovf, sat, xfer, pop, wr, nonempty;
    logic [pOWIDTH-1:0] s_l, s_h;
    logic [pOWIDTH:0] ql, qh;
    logic [2*pOWIDTH-1:0] mem [pDEPTH];
    logic [2*pOWIDTH-1:0] head;
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign ql = rq(bus.idatL);
    assign qh = rq(bus.idatH);
    assign nonempty = cnt != '0;
    assign xfer = nonempty & bus.ordy;
    assign pop = xfer & (ph == PH_H);
    // a same-cycle H pop frees the slot the incoming pair needs
    assign wr = s_val & ((cnt != (AW+1)'(pDEPTH)) | pop);
    assign head = mem[rp];
    always_comb ph_n = xfer ? (ph == PH_L ? PH_H : PH_L) : ph;
    always_ff @(posedge iclk) begin
        if (!irst) ph <= PH_L;
        else ph <= ph_n;
    end
    always_ff @(posedge iclk) begin
        if (!irst) begin
            s_val <= 1'b0;
            s_l   <= '0;
            s_h   <= '0;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sat   <= 1'b0;
        end else begin
            s_val <= bus.iena;
            if (bus.iena) begin
                s_l <= ql[pOWIDTH-1:0];
                s_h <= qh[pOWIDTH-1:0];
            end
            sat <= sat | (bus.iena & (ql[pOWIDTH] | qh[pOWIDTH]));
            ovf <= ovf | (s_val & ~wr);
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge iclk) begin
        if (irst && wr) mem[wp] <= {s_h, s_l};
    end
    assign bus.oval = nonempty;
    assign bus.odat = !nonempty ? '0 : ph == PH_H ? head[2*pOWIDTH-1:pOWIDTH] : head[pOWIDTH-1:0];
    assign bus.osel = ph == PH_H;
    assign bus.oovf = ovf;
    assign bus.osat = sat;
endmodule
